// File: rtl/wm_cycle_controller_if.sv
// Washing-machine controller bus.
// Groups the operator controls, the phase-timer link (phase code out,
// sticky completion flags in) and the actuator/status outputs.
//   master : controller side (drives state code, actuators, status)
//   slave  : environment side (panel, door switch, phase timer, plant)
interface wm_cycle_controller_if;
    // operator panel / door switch
    logic       start;
    logic       door_closed;
    logic       cancel;
    logic       pause;
    logic       cold_wash;
    // phase timer completion flags (sticky)
    logic       sig_Full;
    logic       sig_Temperature;
    logic       sig_Wash_Completed;
    logic       sig_Rinse_Completed;
    logic       sig_Spin_Completed;
    // phase code to timer, actuators, status
    logic [2:0] state;
    logic       door_lock;
    logic       water_valve;
    logic       heater;
    logic       motor;
    logic       busy;
    logic       done;
    logic       fault;

    modport master (
        input  start, door_closed, cancel, pause, cold_wash,
        input  sig_Full, sig_Temperature, sig_Wash_Completed,
               sig_Rinse_Completed, sig_Spin_Completed,
        output state, door_lock, water_valve, heater, motor,
               busy, done, fault
    );

    modport slave (
        output start, door_closed, cancel, pause, cold_wash,
        output sig_Full, sig_Temperature, sig_Wash_Completed,
               sig_Rinse_Completed, sig_Spin_Completed,
        input  state, door_lock, water_valve, heater, motor,
               busy, done, fault
    );
endinterface

// File: rtl/wm_cycle_controller.sv
// Washing-machine cycle sequencer.
// Steps FILL -> (HEAT) -> WASH -> RINSE -> SPIN -> DONE, driving a 3-bit
// phase code into the phase timer and advancing on the timer's sticky
// completion flag for the current phase only. Adds cold-wash skip,
// pause/resume, cancel, door-open interlock and a per-phase watchdog.
// Ports:
//   clock    rising-edge system clock
//   reset_n  asynchronous active-low reset
//   bus      controller bus (master side): inputs start/door_closed/
//            cancel/pause/cold_wash and sig_* flags; outputs state code,
//            door_lock, water_valve, heater, motor, busy, done, fault.
// All outputs are registered and decoded from the next state, so they
// always line up with the registered state.
module wm_cycle_controller #(
    parameter int WDT_LIMIT = 15,
    parameter int WDT_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    wm_cycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_READY, S_FILL, S_HEAT, S_WASH,
        S_RINSE, S_SPIN, S_PAUSED, S_DONE, S_FAULT
    } st_t;

    localparam logic [WDT_WIDTH-1:0] WDT_LAST = WDT_WIDTH'(WDT_LIMIT - 1);

    st_t                 state_q, state_d;
    st_t                 saved_q, saved_d;   // phase to resume after PAUSED
    logic                cold_q,  cold_d;
    logic [WDT_WIDTH-1:0] wdt_q,  wdt_d;

    logic       phase_flag;   // completion flag of the phase we are in
    st_t        phase_next;   // successor of the current phase
    logic [2:0] code_d;
    logic       lock_d, valve_d, heat_d, motor_d, busy_d, done_d, fault_d;

    // Only the current phase's flag matters; earlier sticky flags are ignored.
    always_comb begin
        phase_flag = 1'b0;
        phase_next = state_q;
        case (state_q)
            S_FILL:  begin phase_flag = bus.sig_Full;
                           phase_next = cold_q ? S_WASH : S_HEAT; end
            S_HEAT:  begin phase_flag = bus.sig_Temperature;     phase_next = S_WASH;  end
            S_WASH:  begin phase_flag = bus.sig_Wash_Completed;  phase_next = S_RINSE; end
            S_RINSE: begin phase_flag = bus.sig_Rinse_Completed; phase_next = S_SPIN;  end
            S_SPIN:  begin phase_flag = bus.sig_Spin_Completed;  phase_next = S_DONE;  end
            default: begin phase_flag = 1'b0;                    phase_next = state_q; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cold_d  = cold_q;
        wdt_d   = wdt_q;
        case (state_q)
            S_IDLE:  if (bus.door_closed) state_d = S_READY;
            S_READY: begin
                if (!bus.door_closed) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    state_d = S_FILL;
                    cold_d  = bus.cold_wash;
                    wdt_d   = '0;
                end
            end
            S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else if (!bus.door_closed) begin
                    state_d = S_FAULT;
                end else if (!phase_flag && wdt_q == WDT_LAST) begin
                    state_d = S_FAULT;
                end else if (phase_flag) begin
                    // completion beats a simultaneous pause
                    state_d = phase_next;
                    wdt_d   = '0;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                    if (bus.pause) begin
                        state_d = S_PAUSED;
                        saved_d = state_q;
                    end
                end
            end
            // Watchdog holds here; resuming is not a new phase entry.
            S_PAUSED: begin
                if (bus.cancel)            state_d = S_IDLE;
                else if (!bus.door_closed) state_d = S_FAULT;
                else if (!bus.pause)       state_d = saved_q;
            end
            S_DONE:  if (!bus.door_closed) state_d = S_IDLE;
            S_FAULT: if (bus.cancel && !bus.door_closed) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from next state; registered below.
    always_comb begin
        code_d  = 3'd0;
        lock_d  = 1'b0;
        valve_d = 1'b0;
        heat_d  = 1'b0;
        motor_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            S_READY:  code_d = 3'd1;
            S_FILL:   begin code_d = 3'd2; lock_d = 1'b1; busy_d = 1'b1; valve_d = 1'b1; end
            S_HEAT:   begin code_d = 3'd3; lock_d = 1'b1; busy_d = 1'b1; heat_d  = 1'b1; end
            S_WASH:   begin code_d = 3'd4; lock_d = 1'b1; busy_d = 1'b1; motor_d = 1'b1; end
            S_RINSE:  begin code_d = 3'd5; lock_d = 1'b1; busy_d = 1'b1; motor_d = 1'b1; end
            S_SPIN:   begin code_d = 3'd6; lock_d = 1'b1; busy_d = 1'b1; motor_d = 1'b1; end
            S_PAUSED: begin code_d = 3'd7; lock_d = 1'b1; busy_d = 1'b1; end
            S_DONE:   done_d  = 1'b1;
            S_FAULT:  fault_d = 1'b1;
            default:  code_d  = 3'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            saved_q         <= S_FILL;
            cold_q          <= 1'b0;
            wdt_q           <= '0;
            bus.state       <= 3'd0;
            bus.door_lock   <= 1'b0;
            bus.water_valve <= 1'b0;
            bus.heater      <= 1'b0;
            bus.motor       <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.fault       <= 1'b0;
        end else begin
            state_q         <= state_d;
            saved_q         <= saved_d;
            cold_q          <= cold_d;
            wdt_q           <= wdt_d;
            bus.state       <= code_d;
            bus.door_lock   <= lock_d;
            bus.water_valve <= valve_d;
            bus.heater      <= heat_d;
            bus.motor       <= motor_d;
            bus.busy        <= busy_d;
            bus.done        <= done_d;
            bus.fault       <= fault_d;
        end
    end

endmodule
